// File: rtl/evm_stack.sv
// EVM operand stack: 16-entry register window over a single-port RAM.
// Spills on push into a full window, refills after deep pops.
module evm_stack #(
    parameter int DEPTH  = 1024,
    parameter int WIDTH  = 256,
    parameter int WINDOW = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          op_valid,
    output logic                          op_ready,
    input  logic [4:0]                    pop_num,
    input  logic [4:0]                    push_num,
    input  logic [WIDTH-1:0]              push_data,
    output logic [WINDOW-1:0][WIDTH-1:0]  stack_data,
    output logic [10:0]                   stack_height,
    output logic                          err,
    output logic [1:0]                    err_code
);

    localparam int RAM_DEPTH = DEPTH - WINDOW;
    localparam int AW        = $clog2(RAM_DEPTH);

    typedef enum logic {IDLE, FILL} state_t;

    state_t                       state_q, state_d;
    logic [10:0]                  height_q;
    logic [WINDOW-1:0][WIDTH-1:0] win_q;
    logic                         err_q;
    logic [1:0]                   code_q;
    logic [AW-1:0]                rd_addr_q;
    logic [4:0]                   rd_cnt_q;
    logic [4:0]                   wr_cnt_q;
    logic [3:0]                   wr_slot_q;
    logic                         rvld_q;

    logic [WIDTH-1:0] mem [RAM_DEPTH];
    logic [WIDTH-1:0] ram_q;

    logic [11:0] h12, pop12, push12, hn, lo_o, lo_n, m;
    logic        accept, illegal, under, over, legal, spill;
    logic        ram_re;
    logic [AW-1:0] ram_addr;
    logic [WINDOW-1:0][WIDTH-1:0] sh, nw;

    assign op_ready     = (state_q == IDLE);
    assign stack_data   = win_q;
    assign stack_height = height_q;
    assign err          = err_q;
    assign err_code     = code_q;

    always_comb begin
        h12     = {1'b0, height_q};
        pop12   = {7'b0, pop_num};
        push12  = {7'b0, push_num};
        illegal = (push_num > 5'd1) || (pop_num > 5'(WINDOW));
        under   = pop12 > h12;
        hn      = h12 - pop12 + push12;
        over    = hn > 12'(DEPTH);
        accept  = op_valid && op_ready;
        legal   = accept && !illegal && !under && !over;
        spill   = legal && (pop_num == 5'd0) && push_num[0]
                  && (h12 >= 12'(WINDOW));
        // m: positions now inside the window that only exist in RAM
        lo_o = (h12 > 12'(WINDOW)) ? h12 - 12'(WINDOW) : 12'd0;
        lo_n = (hn > 12'(WINDOW)) ? hn - 12'(WINDOW) : 12'd0;
        m    = (lo_o > lo_n) ? lo_o - lo_n : 12'd0;
    end

    always_comb begin
        sh = '0;
        for (int i = 0; i < WINDOW; i++) begin
            if (i + int'(pop_num) < WINDOW) begin
                sh[i] = win_q[i + int'(pop_num)];
            end
        end
        nw = sh;
        if (push_num[0]) begin
            nw[0] = push_data;
            for (int i = 1; i < WINDOW; i++) begin
                nw[i] = sh[i-1];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (legal && m != 12'd0) state_d = FILL;
            FILL: if (rvld_q && wr_cnt_q == 5'd1) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign ram_re   = (state_q == FILL) && (rd_cnt_q != 5'd0);
    assign ram_addr = spill ? AW'(h12 - 12'(WINDOW)) : rd_addr_q;

    always_ff @(posedge clk) begin
        if (spill) begin
            mem[ram_addr] <= win_q[WINDOW-1];
        end else if (ram_re) begin
            ram_q <= mem[ram_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            height_q  <= '0;
            win_q     <= '0;
            err_q     <= 1'b0;
            code_q    <= 2'b00;
            rd_addr_q <= '0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            wr_slot_q <= '0;
            rvld_q    <= 1'b0;
        end else begin
            err_q  <= 1'b0;
            rvld_q <= ram_re;
            if (accept && !legal) begin
                err_q  <= 1'b1;
                code_q <= illegal ? 2'b11 : (under ? 2'b01 : 2'b10);
            end else if (legal) begin
                code_q   <= 2'b00;
                height_q <= hn[10:0];
                win_q    <= nw;
                if (m != 12'd0) begin
                    rd_addr_q <= AW'(h12 - 12'(WINDOW) - 12'd1);
                    rd_cnt_q  <= m[4:0];
                    wr_cnt_q  <= m[4:0];
                    wr_slot_q <= 4'(5'(WINDOW) - pop_num + push_num);
                end
            end
            if (ram_re) begin
                rd_addr_q <= rd_addr_q - 1'b1;
                rd_cnt_q  <= rd_cnt_q - 5'd1;
            end
            if (rvld_q) begin
                win_q[wr_slot_q] <= ram_q;
                wr_slot_q        <= wr_slot_q + 4'd1;
                wr_cnt_q         <= wr_cnt_q - 5'd1;
            end
        end
    end

endmodule
